// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg : shared AHB-Lite types, response codes and byte-lane helper
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3
  } hsize_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR1 = 2'd2,
    ERR2 = 2'd3
  } state_t;

  // Lanes touched by a transfer of the given size starting at addr_lsbs.
  function automatic logic [7:0] byte_strobe(input hsize_t hsize,
                                             input logic [2:0] addr_lsbs,
                                             input int nbytes);
    logic [7:0] s;
    int lo;
    int hi;
    s  = '0;
    lo = int'(addr_lsbs);
    hi = lo + (1 << hsize);
    for (int i = 0; i < 8; i++) begin
      if (i >= lo && i < hi && i < nbytes) s[i] = 1'b1;
    end
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_mem_array.sv
// ---------------------------------------------------------------------------
// ahb_mem_array : byte-enabled synchronous-write RAM with combinational read
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ahb_mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 128
) (
  input  logic                          i_clk,
  input  logic                          i_we,
  input  logic [DATA_WIDTH/8-1:0]       i_strb,
  input  logic [$clog2(MEM_DEPTH)-1:0]  i_waddr,
  input  logic [DATA_WIDTH-1:0]         i_wdata,
  input  logic [$clog2(MEM_DEPTH)-1:0]  i_raddr,
  output logic [DATA_WIDTH-1:0]         o_rdata
);

  localparam int NBYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  // Contents are deliberately not reset so the array maps onto plain RAM.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (i_strb[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/ahb_mem_slave.sv
// ---------------------------------------------------------------------------
// ahb_mem_slave : AHB-Lite memory slave with byte lanes, wait states, ERROR
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ahb_mem_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 128,
  parameter int WAIT_STATES = 0
) (
  input  logic                   hclk,
  input  logic                   hresetn,
  input  logic                   hsel,
  input  logic                   hready_in,
  input  logic [ADDR_WIDTH-1:0]  haddr,
  input  logic                   hwrite,
  input  logic [1:0]             htrans,
  input  logic [2:0]             hsize,
  input  logic [DATA_WIDTH-1:0]  hwdata,
  output logic                   hready,
  output logic                   hresp,
  output logic [DATA_WIDTH-1:0]  hrdata
);

  localparam int         NBYTES    = DATA_WIDTH / 8;
  localparam int         BSHIFT    = $clog2(NBYTES);
  localparam int         IDX_W     = $clog2(MEM_DEPTH);
  localparam int         AW        = IDX_W + BSHIFT;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [3:0]             r_cnt;
  logic [3:0]             w_cnt_nxt;
  logic [AW-1:0]          r_addr;
  logic                   r_write;
  logic [2:0]             r_size;
  logic                   r_pend;
  logic [DATA_WIDTH-1:0]  r_rdata;

  logic                   w_accept;
  logic                   w_err;
  logic                   w_valid;
  logic                   w_hready;
  logic                   w_hresp;
  logic [ADDR_WIDTH-1:0]  w_widx;
  logic [7:0]             w_align_mask;
  logic                   w_wr_en;
  logic                   w_rd_load;
  logic [NBYTES-1:0]      w_strb;
  logic [DATA_WIDTH-1:0]  w_bmask;
  logic [IDX_W-1:0]       w_wr_idx;
  logic [IDX_W-1:0]       w_rd_idx;
  logic [DATA_WIDTH-1:0]  w_mem_rdata;
  logic [DATA_WIDTH-1:0]  w_rd_word;

  assign w_accept     = hsel & hready_in & htrans[1];
  assign w_widx       = haddr >> BSHIFT;
  assign w_align_mask = (8'd1 << hsize) - 8'd1;
  assign w_err        = (w_widx >= ADDR_WIDTH'(MEM_DEPTH))
                      | (hsize > 3'(BSHIFT))
                      | (|(haddr[2:0] & w_align_mask[2:0]));
  assign w_valid      = w_accept & ~w_err;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hready    = 1'b1;
    w_hresp     = HRESP_OKAY;
    case (r_state)
      WAIT: begin
        if (r_cnt != 4'd0) begin
          w_hready  = 1'b0;
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ERR1: begin
        w_hready    = 1'b0;
        w_hresp     = HRESP_ERROR;
        w_state_nxt = ERR2;
      end
      ERR2: begin
        w_hresp     = HRESP_ERROR;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    // A new address phase can only land on a cycle where we drive hready high.
    if (w_hready && w_accept) begin
      if (w_err) begin
        w_state_nxt = ERR1;
      end else if (WAIT_STATES > 0) begin
        w_state_nxt = WAIT;
        w_cnt_nxt   = WAIT_LOAD;
      end
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_addr  <= '0;
      r_write <= 1'b0;
      r_size  <= '0;
      r_pend  <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= haddr[AW-1:0];
        r_write <= hwrite;
        r_size  <= hsize;
      end
      if (w_hready) r_pend <= w_valid;
      if (w_rd_load) r_rdata <= w_rd_word;
    end
  end

  assign w_wr_en  = r_pend & r_write & w_hready;
  assign w_strb   = NBYTES'(byte_strobe(hsize_t'(r_size), 3'(r_addr[BSHIFT-1:0]), NBYTES));
  assign w_wr_idx = r_addr[BSHIFT +: IDX_W];

  always_comb begin
    w_bmask = '0;
    for (int b = 0; b < NBYTES; b++) w_bmask[b*8 +: 8] = {8{w_strb[b]}};
  end

  // Read data is registered so it is stable for the whole hready-high cycle:
  // with no wait states it is fetched at the address-phase edge, otherwise
  // on the edge that enters the final data-phase cycle.
  assign w_rd_idx  = (WAIT_STATES == 0) ? haddr[BSHIFT +: IDX_W] : r_addr[BSHIFT +: IDX_W];
  assign w_rd_load = (WAIT_STATES == 0)
                   ? (w_hready & w_valid & ~hwrite)
                   : ((r_state == WAIT) & (r_cnt == 4'd1) & r_pend & ~r_write);

  // A read issued right behind a write to the same word must see the bytes
  // that are being committed on this very edge.
  assign w_rd_word = (w_wr_en && (w_wr_idx == w_rd_idx))
                   ? ((w_mem_rdata & ~w_bmask) | (hwdata & w_bmask))
                   : w_mem_rdata;

  ahb_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_mem (
    .i_clk   (hclk),
    .i_we    (w_wr_en),
    .i_strb  (w_strb),
    .i_waddr (w_wr_idx),
    .i_wdata (hwdata),
    .i_raddr (w_rd_idx),
    .o_rdata (w_mem_rdata)
  );

  assign hready = w_hready;
  assign hresp  = w_hresp;
  assign hrdata = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_ahb_mem_slave.sv
// ---------------------------------------------------------------------------
// tb_ahb_mem_slave : scoreboard bench, zero-wait and 3-wait-state slaves
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_ahb_mem_slave;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        hsel_bus = 1'b0;
  logic        tgt = 1'b0;
  logic        force_low = 1'b0;
  logic        mon_en = 1'b1;
  logic [9:0]  haddr = '0;
  logic        hwrite = 1'b0;
  logic [1:0]  htrans = 2'b00;
  logic [2:0]  hsize = 3'd0;
  logic [31:0] hwdata = '0;

  logic        hsel0, hsel1, hready0, hready1, hresp0, hresp1;
  logic [31:0] hrdata0, hrdata1;
  logic        bus_hready, bus_hready_in, bus_hresp;
  logic [31:0] bus_hrdata;

  always #5 hclk = ~hclk;

  assign hsel0         = hsel_bus & ~tgt;
  assign hsel1         = hsel_bus & tgt;
  assign bus_hready    = hready0 & hready1;
  assign bus_hready_in = bus_hready & ~force_low;
  assign bus_hresp     = hresp0 | hresp1;
  assign bus_hrdata    = tgt ? hrdata1 : hrdata0;

  ahb_mem_slave #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .MEM_DEPTH(128), .WAIT_STATES(0)) u_dut0 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel0), .hready_in(bus_hready_in),
    .haddr(haddr), .hwrite(hwrite), .htrans(htrans), .hsize(hsize), .hwdata(hwdata),
    .hready(hready0), .hresp(hresp0), .hrdata(hrdata0));

  ahb_mem_slave #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .MEM_DEPTH(128), .WAIT_STATES(3)) u_dut3 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel1), .hready_in(bus_hready_in),
    .haddr(haddr), .hwrite(hwrite), .htrans(htrans), .hsize(hsize), .hwdata(hwdata),
    .hready(hready1), .hresp(hresp1), .hrdata(hrdata1));

  typedef struct {
    logic        chk_data;
    logic [31:0] data;
    logic        resp;
    int          stalls;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_fail = 0;
  int   dp_cycles = 0;
  bit   mon_busy = 1'b0;
  int   m_cyc = 0;
  int   m_stalls = 0;
  logic m_first = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: follows data phases on the bus and scores each completed one.
  always @(negedge hclk) begin
    exp_t e;
    if (!hresetn) begin
      mon_busy = 1'b0;
    end else if (mon_en) begin
      if (mon_busy) begin
        m_cyc++;
        dp_cycles++;
        if (m_cyc == 1) m_first = bus_hresp;
        if (!bus_hready) begin
          m_stalls++;
          if (m_cyc > 40) begin
            n_vec++; n_fail++;
            $display("FAIL dphase_timeout: got %0d cycles required <= 40", m_cyc);
            mon_busy = 1'b0;
          end
        end else begin
          mon_busy = 1'b0;
          if (sb_q.size() == 0) begin
            n_vec++; n_fail++;
            $display("FAIL unexpected_dphase: got completion required none");
          end else begin
            e = sb_q.pop_front();
            check("stalls", 32'(m_stalls), 32'(e.stalls));
            check("hresp_first", {31'd0, m_first}, {31'd0, e.resp});
            check("hresp_last", {31'd0, bus_hresp}, {31'd0, e.resp});
            if (e.chk_data) check("hrdata", bus_hrdata, e.data);
          end
        end
      end
      if (hsel_bus && bus_hready_in && htrans[1]) begin
        mon_busy = 1'b1;
        m_cyc    = 0;
        m_stalls = 0;
      end
    end
  end

  task automatic issue(input logic [1:0] tr, input logic [9:0] a, input logic w,
                       input logic [2:0] sz, input logic [31:0] wd,
                       input logic [31:0] rd_exp, input bit err);
    exp_t e;
    bit   ok;
    hsel_bus = 1'b1; htrans = tr; haddr = a; hwrite = w; hsize = sz;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge hclk);
      if (bus_hready_in) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++; n_fail++;
      $display("FAIL accept_timeout: got hready low for 50 cycles required high at %h", a);
    end
    @(posedge hclk); #1;
    hwdata     = w ? wd : 32'h0;
    e.chk_data = !w && !err;
    e.data     = rd_exp;
    e.resp     = err;
    e.stalls   = err ? 1 : (tgt ? 3 : 0);
    sb_q.push_back(e);
  endtask

  task automatic drain();
    bit ok;
    hsel_bus = 1'b0; htrans = 2'b00; hwrite = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge hclk);
      if (sb_q.size() == 0 && !mon_busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++; n_fail++;
      $display("FAIL drain_timeout: got %0d pending required 0", sb_q.size());
    end
    @(posedge hclk); #1;
  endtask

  initial begin
    int base;
    repeat (3) @(posedge hclk);
    #1;
    check("rst_hready", {31'd0, hready0}, 32'd1);
    check("rst_hresp", {31'd0, hresp0}, 32'd0);
    check("rst_hrdata", hrdata0, 32'h0);
    hresetn = 1'b1;
    @(posedge hclk); #1;

    // Zero wait states: write then back-to-back read (bypass), then a plain read.
    tgt = 1'b0;
    issue(2'b10, 10'h004, 1'b1, 3'd2, 32'hDEADBEEF, 32'h0, 1'b0);
    issue(2'b10, 10'h004, 1'b0, 3'd2, 32'h0, 32'hDEADBEEF, 1'b0);
    drain();
    issue(2'b10, 10'h004, 1'b0, 3'd2, 32'h0, 32'hDEADBEEF, 1'b0);
    drain();

    // Byte lanes, with the read directly behind the half-word write.
    issue(2'b10, 10'h008, 1'b1, 3'd2, 32'h11223344, 32'h0, 1'b0);
    issue(2'b10, 10'h009, 1'b1, 3'd0, 32'h0000AA00, 32'h0, 1'b0);
    issue(2'b10, 10'h00A, 1'b1, 3'd1, 32'hBBCC0000, 32'h0, 1'b0);
    issue(2'b10, 10'h008, 1'b0, 3'd2, 32'h0, 32'hBBCCAA44, 1'b0);
    drain();

    // Error responses; none of them may disturb word 0.
    issue(2'b10, 10'h000, 1'b1, 3'd2, 32'hCAFEF00D, 32'h0, 1'b0);
    issue(2'b10, 10'h1FC, 1'b1, 3'd2, 32'h600DCAFE, 32'h0, 1'b0);
    issue(2'b10, 10'h200, 1'b1, 3'd2, 32'h12345678, 32'h0, 1'b1);
    issue(2'b10, 10'h002, 1'b1, 3'd2, 32'h55555555, 32'h0, 1'b1);
    issue(2'b10, 10'h001, 1'b1, 3'd1, 32'h66666666, 32'h0, 1'b1);
    issue(2'b10, 10'h000, 1'b1, 3'd3, 32'h77777777, 32'h0, 1'b1);
    issue(2'b10, 10'h200, 1'b0, 3'd2, 32'h0, 32'h0, 1'b1);
    issue(2'b10, 10'h000, 1'b0, 3'd2, 32'h0, 32'hCAFEF00D, 1'b0);
    issue(2'b10, 10'h1FC, 1'b0, 3'd2, 32'h0, 32'h600DCAFE, 1'b0);
    drain();

    // BUSY, unselected and hready_in-low transfers must be ignored.
    hsel_bus = 1'b1; htrans = 2'b01; haddr = 10'h000; hwrite = 1'b1; hsize = 3'd2;
    @(posedge hclk); #1;
    hwdata = 32'hFFFFFFFF; hsel_bus = 1'b0; htrans = 2'b10;
    @(negedge hclk);
    check("busy_hready", {31'd0, hready0}, 32'd1);
    check("busy_hresp", {31'd0, hresp0}, 32'd0);
    @(posedge hclk); #1;
    hsel_bus = 1'b1; force_low = 1'b1;
    @(negedge hclk);
    check("unsel_hready", {31'd0, hready0}, 32'd1);
    @(posedge hclk); #1;
    force_low = 1'b0; hsel_bus = 1'b0; htrans = 2'b00;
    @(negedge hclk);
    check("ignored_hready", {31'd0, hready0}, 32'd1);
    @(posedge hclk); #1;
    issue(2'b10, 10'h000, 1'b0, 3'd2, 32'h0, 32'hCAFEF00D, 1'b0);
    drain();

    // Three wait states.
    tgt = 1'b1;
    issue(2'b10, 10'h010, 1'b1, 3'd2, 32'h0BADF00D, 32'h0, 1'b0);
    issue(2'b10, 10'h014, 1'b1, 3'd2, 32'h01020304, 32'h0, 1'b0);
    issue(2'b10, 10'h018, 1'b1, 3'd2, 32'hA5A55A5A, 32'h0, 1'b0);
    drain();
    issue(2'b10, 10'h010, 1'b0, 3'd2, 32'h0, 32'h0BADF00D, 1'b0);
    drain();
    base = dp_cycles;
    issue(2'b10, 10'h010, 1'b0, 3'd2, 32'h0, 32'h0BADF00D, 1'b0);
    issue(2'b11, 10'h014, 1'b0, 3'd2, 32'h0, 32'h01020304, 1'b0);
    issue(2'b11, 10'h018, 1'b0, 3'd2, 32'h0, 32'hA5A55A5A, 1'b0);
    drain();
    check("burst_cycles", 32'(dp_cycles - base), 32'd12);
    issue(2'b10, 10'h200, 1'b1, 3'd2, 32'h12345678, 32'h0, 1'b1);
    drain();

    // Reset in the middle of a stalled write.
    mon_en = 1'b0;
    hsel_bus = 1'b1; htrans = 2'b10; haddr = 10'h010; hwrite = 1'b1; hsize = 3'd2;
    @(posedge hclk); #1;
    hwdata = 32'hFFFFFFFF; hsel_bus = 1'b0; htrans = 2'b00; hwrite = 1'b0;
    @(negedge hclk);
    check("midwr_stall", {31'd0, hready1}, 32'd0);
    hresetn = 1'b0;
    #1;
    check("midrst_hready", {31'd0, hready1}, 32'd1);
    check("midrst_hresp", {31'd0, hresp1}, 32'd0);
    check("midrst_hrdata", hrdata1, 32'h0);
    @(posedge hclk); #1;
    hresetn = 1'b1;
    @(posedge hclk); #1;
    mon_en = 1'b1;
    issue(2'b10, 10'h010, 1'b0, 3'd2, 32'h0, 32'h0BADF00D, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
